decode_queue: RTL and testbench

Buffered, parametrised successor to the combinational instruction decoder: accepts fetched RV64IM instructions over a valid/ready handshake, decodes each on entry, and holds up to DEPTH decoded entries in a circular queue for the execute stage. Sits between fetch and execute, and decouples their stalls. Beyond the existing decode, it adds register-index extraction, memory size and sign fields, illegal-instruction detection and a pipeline flush.

---
 rtl/decode_queue.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Purpose : decode RV64IM instructions on entry and hold up to DEPTH decoded entries for execute.
// Latency : 1 cycle from accept (in_valid & in_ready) to head visibility on an empty queue; no in->out comb path.
// Backpressure: in_ready = not full and no flush; out_valid = not empty; payload stable while stalled.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               drop every queued entry at the next edge
//   in_valid/in_ready   fetch handshake carrying in_instr and in_pc
//   out_valid/out_ready execute handshake; out_* present the decoded head entry (zero when empty)
//   count               current occupancy

package decode_queue_pkg;

   typedef enum logic [3:0] {
      OP_ALUI, OP_ALU, OP_ALUIW, OP_ALUW, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LD, OP_SD
   } op_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_COMPARE
   } alufunc_t;

   typedef struct packed {
      op_t      op;
      alufunc_t alufunc;
      logic     regwrite;
   } contral_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      contral_t    ctl;
      logic        branch;
      logic        ismem;
      logic        illegal;
      logic [1:0]  memsize;
      logic        memunsigned;
   } entry_t;

   localparam logic [6:0] OPC_ALUI   = 7'b0010011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
   localparam logic [6:0] OPC_ALUW   = 7'b0111011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LD     = 7'b0000011;
   localparam logic [6:0] OPC_SD     = 7'b0100011;

endpackage

module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic [63:0]   in_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   out_pc,
   output logic [31:0]   out_instr,
   output contral_t      out_ctl,
   output logic          out_branch,
   output logic          out_ismem,
   output logic          out_illegal,
   output logic [4:0]    out_rd,
   output logic [4:0]    out_rs1,
   output logic [4:0]    out_rs2,
   output logic [1:0]    out_memsize,
   output logic          out_memunsigned,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   // funct3 table shared by register and immediate ALU forms; alt picks SUB/SRA.
   function automatic alufunc_t base_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // M extension: all multiply variants collapse onto the single multiplier op.
   function automatic alufunc_t m_alu(input logic [2:0] f3);
      case (f3)
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         3'b111:  return ALU_REMU;
         default: return ALU_MULT;
      endcase
   endfunction

   function automatic op_t branch_op(input logic [2:0] f3);
      case (f3)
         3'b001:  return OP_BNE;
         3'b100:  return OP_BLT;
         3'b101:  return OP_BGE;
         3'b110:  return OP_BLTU;
         3'b111:  return OP_BGEU;
         default: return OP_BEQ;
      endcase
   endfunction

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        mem_q [DEPTH];
   entry_t        dec;
   entry_t        head_e;
   logic          push, pop;
   logic          ill;
   logic [2:0]    f3;
   logic [6:0]    f7;

   assign f3 = in_instr[14:12];
   assign f7 = in_instr[31:25];

   // ---------------- decode on entry ----------------
   always_comb begin
      dec                  = '0;
      dec.pc               = in_pc;
      dec.instr            = in_instr;
      dec.ctl.op           = OP_ALUI;
      dec.ctl.alufunc      = ALU_ADD;
      dec.ctl.regwrite     = 1'b0;
      ill                  = 1'b0;
      case (in_instr[6:0])
         OPC_ALUI, OPC_ALUIW: begin
            // Immediate forms have no SUB; bit 30 only distinguishes SRAI from SRLI.
            dec.ctl.op       = (in_instr[6:0] == OPC_ALUI) ? OP_ALUI : OP_ALUIW;
            dec.ctl.alufunc  = base_alu(f3, (f3 == 3'b101) && in_instr[30]);
            dec.ctl.regwrite = 1'b1;
         end
         OPC_ALU, OPC_ALUW: begin
            dec.ctl.op       = (in_instr[6:0] == OPC_ALU) ? OP_ALU : OP_ALUW;
            dec.ctl.regwrite = 1'b1;
            case (f7)
               7'b0000000: dec.ctl.alufunc = base_alu(f3, 1'b0);
               7'b0100000: begin
                  if ((f3 == 3'b000) || (f3 == 3'b101)) dec.ctl.alufunc = base_alu(f3, 1'b1);
                  else                                  ill = 1'b1;
               end
               7'b0000001: dec.ctl.alufunc = m_alu(f3);
               default:    ill = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec.ctl.op       = OP_LUI;
            dec.ctl.regwrite = 1'b1;
         end
         OPC_AUIPC: begin
            dec.ctl.op       = OP_AUIPC;
            dec.ctl.regwrite = 1'b1;
         end
         OPC_JAL: begin
            dec.ctl.op       = OP_JAL;
            dec.ctl.regwrite = 1'b1;
            dec.branch       = 1'b1;
         end
         OPC_JALR: begin
            dec.ctl.op       = OP_JALR;
            dec.ctl.regwrite = 1'b1;
            dec.branch       = 1'b1;
            ill              = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.ctl.op      = branch_op(f3);
            dec.ctl.alufunc = ALU_COMPARE;
            dec.branch      = 1'b1;
            ill             = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LD: begin
            dec.ctl.op       = OP_LD;
            dec.ctl.regwrite = 1'b1;
            dec.ismem        = 1'b1;
            dec.memsize      = f3[1:0];
            dec.memunsigned  = f3[2];
            ill              = (f3 == 3'b111);
         end
         OPC_SD: begin
            dec.ctl.op  = OP_SD;
            dec.ismem   = 1'b1;
            dec.memsize = f3[1:0];
            ill         = f3[2];
         end
         default: ill = 1'b1;
      endcase

      // Illegal entries become a harmless non-writing ADDI shell; pc/instr kept for the trap.
      if (ill) begin
         dec.ctl.op       = OP_ALUI;
         dec.ctl.alufunc  = ALU_ADD;
         dec.ctl.regwrite = 1'b0;
         dec.branch       = 1'b0;
         dec.ismem        = 1'b0;
         dec.memsize      = 2'd0;
         dec.memunsigned  = 1'b0;
         dec.illegal      = 1'b1;
      end
   end

   // ---------------- handshake and pointers ----------------
   assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PW'(1);
         if (pop)  head_d = head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= dec;
   end

   // ---------------- head presentation ----------------
   always_comb begin
      head_e = '0;
      if (out_valid) head_e = mem_q[head_q];
   end

   assign out_pc          = head_e.pc;
   assign out_instr       = head_e.instr;
   assign out_ctl         = head_e.ctl;
   assign out_branch      = head_e.branch;
   assign out_ismem       = head_e.ismem;
   assign out_illegal     = head_e.illegal;
   assign out_rd          = head_e.instr[11:7];
   assign out_rs1         = head_e.instr[19:15];
   assign out_rs2         = head_e.instr[24:20];
   assign out_memsize     = head_e.memsize;
   assign out_memunsigned = head_e.memunsigned;
   assign count           = count_q;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_instr = '0;
   logic [63:0]   in_pc = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [63:0]   out_pc;
   logic [31:0]   out_instr;
   contral_t      out_ctl;
   logic          out_branch, out_ismem, out_illegal;
   logic [4:0]    out_rd, out_rs1, out_rs2;
   logic [1:0]    out_memsize;
   logic          out_memunsigned;
   logic [CW-1:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_ctl(out_ctl), .out_branch(out_branch), .out_ismem(out_ismem), .out_illegal(out_illegal),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_memsize(out_memsize),
      .out_memunsigned(out_memunsigned), .count(count)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [8:0]  ctl;
      logic        branch, ismem, illegal;
      logic [1:0]  memsize;
      logic        memuns;
   } exp_t;

   exp_t mq[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode written straight from the instruction-set rules.
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
      exp_t     e;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic     rtype, known, bad;
      op_t      op;
      alufunc_t a;
      logic     rw;
      alufunc_t base [8];
      alufunc_t mtab [8];
      op_t      brt  [8];
      base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      mtab = '{ALU_MULT, ALU_MULT, ALU_MULT, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      brt  = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BEQ, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
      opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      e = '{pc: pc, instr: w, ctl: '0, branch: 1'b0, ismem: 1'b0, illegal: 1'b0, memsize: 2'd0, memuns: 1'b0};
      known = opc inside {7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
      rtype = (opc == 7'h33) || (opc == 7'h3b);
      bad = !known
         || (opc == 7'h63 && (f3 == 3'd2 || f3 == 3'd3))
         || (rtype && !(f7 inside {7'h00, 7'h20, 7'h01}))
         || (rtype && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))
         || (opc == 7'h23 && f3 > 3'd3)
         || (opc == 7'h03 && f3 == 3'd7)
         || (opc == 7'h67 && f3 != 3'd0);
      if (bad) begin
         e.illegal = 1'b1;
         e.ctl = {OP_ALUI, ALU_ADD, 1'b0};
         return e;
      end
      a = ALU_ADD; rw = 1'b1; op = OP_ALUI;
      case (opc)
         7'h13, 7'h1b: begin
            op = (opc == 7'h13) ? OP_ALUI : OP_ALUIW;
            a = (f3 == 3'd5 && w[30]) ? ALU_SRA : base[f3];
         end
         7'h33, 7'h3b: begin
            op = (opc == 7'h33) ? OP_ALU : OP_ALUW;
            if (f7 == 7'h01)      a = mtab[f3];
            else if (f7 == 7'h20) a = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
            else                  a = base[f3];
         end
         7'h37: op = OP_LUI;
         7'h17: op = OP_AUIPC;
         7'h6f: begin op = OP_JAL;  e.branch = 1'b1; end
         7'h67: begin op = OP_JALR; e.branch = 1'b1; end
         7'h63: begin op = brt[f3]; a = ALU_COMPARE; rw = 1'b0; e.branch = 1'b1; end
         7'h03: begin op = OP_LD; e.ismem = 1'b1; e.memsize = f3[1:0]; e.memuns = f3[2]; end
         default: begin op = OP_SD; rw = 1'b0; e.ismem = 1'b1; e.memsize = f3[1:0]; end
      endcase
      e.ctl = {op, a, rw};
      return e;
   endfunction

   task automatic check_outputs();
      exp_t h;
      logic ev;
      ev = (mq.size() != 0);
      h = ev ? mq[0] : '{pc: '0, instr: '0, ctl: '0, branch: 1'b0, ismem: 1'b0, illegal: 1'b0, memsize: 2'd0, memuns: 1'b0};
      check("count",     64'(count),     64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready",  64'(in_ready),  64'((mq.size() < DEPTH) && !flush));
      check("pc",        out_pc,         h.pc);
      check("instr",     64'(out_instr), 64'(h.instr));
      check("ctl",       64'(out_ctl),   64'(h.ctl));
      check("branch",    64'(out_branch),64'(h.branch));
      check("ismem",     64'(out_ismem), 64'(h.ismem));
      check("illegal",   64'(out_illegal),64'(h.illegal));
      check("rd",        64'(out_rd),    64'(h.instr[11:7]));
      check("rs1",       64'(out_rs1),   64'(h.instr[19:15]));
      check("rs2",       64'(out_rs2),   64'(h.instr[24:20]));
      check("memsize",   64'(out_memsize),64'(h.memsize));
      check("memuns",    64'(out_memunsigned),64'(h.memuns));
   endtask

   // One clock: drive on the falling edge, check the current state, then advance the model.
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic r, input logic f);
      logic acc;
      @(negedge clk);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = r; flush = f;
      #1;
      check_outputs();
      acc = v && (mq.size() < DEPTH) && !f;
      if (f) mq.delete();
      else begin
         if (r && mq.size() != 0) void'(mq.pop_front());
         if (acc) mq.push_back(ref_decode(ins, pc));
      end
   endtask

   task automatic idle(input logic r);
      cyc(1'b0, 32'h0, 64'h0, r, 1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 14);
      case (k)
         0: w[6:0] = 7'h13;  1: w[6:0] = 7'h33;  2: w[6:0] = 7'h1b;
         3: w[6:0] = 7'h3b;  4: w[6:0] = 7'h37;  5: w[6:0] = 7'h17;
         6: w[6:0] = 7'h6f;  7: w[6:0] = 7'h67;  8: w[6:0] = 7'h63;
         9: w[6:0] = 7'h03; 10: w[6:0] = 7'h23;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   logic [31:0] rtype_i [3];
   alufunc_t    rtype_f [3];

   initial begin
      // reset state
      #1;
      check_outputs();
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      reset = 1'b0;

      // addi x1,x0,5
      cyc(1'b1, 32'h00500093, 64'h1000, 1'b0, 1'b0);
      idle(1'b0);
      check("addi_valid", 64'(out_valid), 64'(1));
      check("addi_ctl",   64'(out_ctl),   64'({OP_ALUI, ALU_ADD, 1'b1}));
      check("addi_rd",    64'(out_rd),    64'(1));
      check("addi_rs1",   64'(out_rs1),   64'(0));
      check("addi_count", 64'(count),     64'(1));
      idle(1'b1);

      // add / sub / mul back to back, dequeued in order
      rtype_i = '{32'h002081b3, 32'h402081b3, 32'h022081b3};
      rtype_f = '{ALU_ADD, ALU_SUB, ALU_MULT};
      for (int i = 0; i < 3; i++) cyc(1'b1, rtype_i[i], 64'h2000 + 64'(4*i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         check("rtype_alu", 64'(out_ctl.alufunc), 64'(rtype_f[i]));
         check("rtype_regs", 64'({out_rd, out_rs1, out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
      end

      // ld / sd
      cyc(1'b1, 32'h00813283, 64'h3000, 1'b0, 1'b0);
      cyc(1'b1, 32'h00513423, 64'h3004, 1'b0, 1'b0);
      idle(1'b1);
      check("ld_mem", 64'({out_ismem, out_memsize, out_memunsigned, out_ctl.regwrite}), 64'({1'b1, 2'd3, 1'b0, 1'b1}));
      idle(1'b1);
      check("sd_op", 64'({out_ctl.op, out_ctl.regwrite}), 64'({OP_SD, 1'b0}));

      // beq / all-ones
      cyc(1'b1, 32'h00208463, 64'h4000, 1'b0, 1'b0);
      cyc(1'b1, 32'hffffffff, 64'h4004, 1'b0, 1'b0);
      idle(1'b1);
      check("beq", 64'({out_branch, out_ctl.op, out_ctl.alufunc}), 64'({1'b1, OP_BEQ, ALU_COMPARE}));
      idle(1'b1);
      check("ill", 64'({out_illegal, out_ctl.regwrite, out_branch}), 64'({1'b1, 1'b0, 1'b0}));
      check("ill_pc", out_pc, 64'h4004);

      // fill, then full-with-out_ready, then steady streaming across wrap
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h00100013 + 32'(i << 7), 64'h5000 + 64'(4*i), 1'b0, 1'b0);
      idle(1'b0);
      check("full_count", 64'(count),    64'(DEPTH));
      check("full_rdy",   64'(in_ready), 64'(0));
      cyc(1'b1, 32'h00000033, 64'h5100, 1'b1, 1'b0);
      idle(1'b0);
      check("after_full", 64'(count), 64'(DEPTH - 1));
      for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b1, rand_instr(), 64'h6000 + 64'(4*i), 1'b1, 1'b0);
      idle(1'b0);
      check("stream_count", 64'(count), 64'(DEPTH - 1));
      for (int i = 0; i < DEPTH; i++) idle(1'b1);

      // flush with 3 queued and an offered instruction
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00500093, 64'h7000 + 64'(4*i), 1'b0, 1'b0);
      cyc(1'b1, 32'h002081b3, 64'h7100, 1'b1, 1'b1);
      idle(1'b0);
      check("flush_count", 64'(count),     64'(0));
      check("flush_valid", 64'(out_valid), 64'(0));

      // randomized traffic with a mid-stream asynchronous reset
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
             $urandom_range(0, 9) < (((i / 100) % 2 == 1) ? 3 : 8), $urandom_range(0, 31) == 0);
         if (i == 400) begin
            in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
            #2 reset = 1'b1;
            #1;
            mq.delete();
            check("arst_count", 64'(count),     64'(0));
            check("arst_valid", 64'(out_valid), 64'(0));
            check("arst_rdy",   64'(in_ready),  64'(1));
            check("arst_pc",    out_pc,         64'(0));
            @(negedge clk);
            reset = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
